// File: rtl/dbus_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dbus_responder_if
// Purpose  : dreq/dresp handshake bundle between the core data port and a
//            data-bus responder.
// Revision : 1.0 - initial release
// ============================================================================

interface dbus_responder_if;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

`default_nettype wire

// File: rtl/dbus_responder.sv
`default_nettype none
// ============================================================================
// Module   : dbus_responder
// Purpose  : Fixed-latency data-bus responder backed by a 64-bit word RAM.
// Revision : 1.0 - initial release
// ============================================================================

module dbus_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input wire              clk,
  input wire              reset,
  dbus_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_LAST_CNT = 4'(LATENCY - 1);
  localparam int         c_WORDS    = 1 << AW;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [63:3] r_addr;
  logic [7:0]  r_strobe;
  logic [63:0] r_wdata;
  logic        r_addr_ok;
  logic        r_data_ok;
  logic [63:0] r_rdata;
  logic [63:0] r_mem [c_WORDS];

  logic        w_req_in_range;
  logic        w_lat_in_range;
  logic [63:0] w_req_word;
  logic [63:0] w_lat_word;
  logic [63:0] w_mask;
  logic        w_we;
  logic        w_unused;

  // Byte offset and size are the requester's concern; only the word index matters here.
  assign w_unused = ^{bus.dreq_size, bus.dreq_addr[2:0]};

  assign w_req_in_range = (bus.dreq_addr[63:AW+3] == '0);
  assign w_lat_in_range = (r_addr[63:AW+3] == '0);
  assign w_req_word     = w_req_in_range ? r_mem[bus.dreq_addr[AW+2:3]] : 64'h0;
  assign w_lat_word     = w_lat_in_range ? r_mem[r_addr[AW+2:3]] : 64'h0;

  for (genvar i = 0; i < 8; i++) begin : g_mask
    assign w_mask[8*i +: 8] = {8{r_strobe[i]}};
  end

  // A request withdrawn during RESP still completes but must not commit its store.
  assign w_we = (r_state == S_RESP) && bus.dreq_valid && w_lat_in_range && (|r_strobe);

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_addr[AW+2:3]] <= (r_mem[r_addr[AW+2:3]] & ~w_mask) | (r_wdata & w_mask);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_strobe  <= 8'h00;
      r_wdata   <= 64'h0;
      r_addr_ok <= 1'b0;
      r_data_ok <= 1'b0;
      r_rdata   <= 64'h0;
    end else begin
      r_addr_ok <= 1'b0;
      r_data_ok <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.dreq_valid) begin
            r_addr   <= bus.dreq_addr[63:3];
            r_strobe <= bus.dreq_strobe;
            r_wdata  <= bus.dreq_data;
            r_cnt    <= 4'd1;
            if (LATENCY == 1) begin
              r_state   <= S_RESP;
              r_rdata   <= w_req_word;
              r_addr_ok <= 1'b1;
              r_data_ok <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus.dreq_valid) begin
            r_state <= S_IDLE;
          end else if (r_cnt == c_LAST_CNT) begin
            r_state   <= S_RESP;
            r_rdata   <= w_lat_word;
            r_addr_ok <= 1'b1;
            r_data_ok <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dresp_addr_ok = r_addr_ok;
  assign bus.dresp_data_ok = r_data_ok;
  assign bus.dresp_data    = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dbus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_responder
// Purpose  : Randomized bench for dbus_responder at LATENCY 2, 1 and 15
//            against a word-array memory model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_dbus_responder;

  localparam int c_AW = 10;

  logic   clk = 1'b0;
  logic   reset;
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  tb_valid;
  logic [63:0] tb_addr   [3];
  logic [2:0]  tb_size   [3];
  logic [7:0]  tb_strobe [3];
  logic [63:0] tb_wdata  [3];
  logic [2:0]  w_aok;
  logic [2:0]  w_dok;
  logic [63:0] w_rdata   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dbus_responder_if u_bus ();
    assign u_bus.dreq_valid  = tb_valid[g];
    assign u_bus.dreq_addr   = tb_addr[g];
    assign u_bus.dreq_size   = tb_size[g];
    assign u_bus.dreq_strobe = tb_strobe[g];
    assign u_bus.dreq_data   = tb_wdata[g];
    assign w_aok[g]          = u_bus.dresp_addr_ok;
    assign w_dok[g]          = u_bus.dresp_data_ok;
    assign w_rdata[g]        = u_bus.dresp_data;

    dbus_responder #(
      .AW      (c_AW),
      .LATENCY (g == 0 ? 2 : (g == 1 ? 1 : 15))
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_bus.slave)
    );
  end

  // Reference memory: one word array per responder, plus which words hold known data.
  logic [63:0] m_mem   [3][1024];
  bit          m_known [3][1024];
  longint      last_ok [3];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request starting at posedge+1; returns at posedge+1 of the idle cycle after RESP.
  task automatic txn(input int d, input logic [63:0] addr, input logic [7:0] strobe,
                     input logic [63:0] data, input bit drop_resp, input bit chk_space);
    int         lat;
    int         n;
    bit         got;
    bit         inr;
    logic [9:0] idx;
    lat = lat_of(d);
    inr = (addr[63:13] == '0);
    idx = addr[12:3];
    tb_valid[d]  = 1'b1;
    tb_addr[d]   = addr;
    tb_size[d]   = 3'($urandom_range(0, 3));
    tb_strobe[d] = strobe;
    tb_wdata[d]  = data;
    n   = 0;
    got = 1'b0;
    while (!got && n < lat + 4) begin
      @(posedge clk); #1;
      n++;
      chk("aok_eq_dok", 64'(w_aok[d]), 64'(w_dok[d]));
      if (w_dok[d] === 1'b1) got = 1'b1;
    end
    chk("data_ok_seen", 64'(got), 64'd1);
    if (got) begin
      chk("latency", 64'(n), 64'(lat));
      if (chk_space) chk("spacing", 64'(cyc - last_ok[d]), 64'(lat + 1));
      last_ok[d] = cyc;
      if (!inr) chk("oor_rdata", w_rdata[d], 64'h0);
      else if (m_known[d][idx]) chk("rdata", w_rdata[d], m_mem[d][idx]);
      if (drop_resp) begin
        tb_valid[d] = 1'b0;
      end else if (inr && strobe != 8'h00) begin
        for (int i = 0; i < 8; i++)
          if (strobe[i]) m_mem[d][idx][8*i +: 8] = data[8*i +: 8];
        if (strobe == 8'hFF) m_known[d][idx] = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("pulse_end", 64'(w_dok[d]), 64'd0);
    tb_valid[d] = 1'b0;
  endtask

  task automatic abort_txn(input int d, input logic [63:0] addr, input logic [7:0] strobe,
                           input logic [63:0] data, input int hold);
    bit seen;
    seen = 1'b0;
    tb_valid[d]  = 1'b1;
    tb_addr[d]   = addr;
    tb_strobe[d] = strobe;
    tb_wdata[d]  = data;
    repeat (hold) @(posedge clk);
    #1;
    tb_valid[d] = 1'b0;
    repeat (lat_of(d) + 2) begin
      @(posedge clk); #1;
      if (w_dok[d] === 1'b1) seen = 1'b1;
    end
    chk("abort_no_ok", 64'(seen), 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    logic [7:0]  s;
    bit          back;
    int          lat;

    tb_valid = 3'b000;
    for (int d = 0; d < 3; d++) begin
      tb_addr[d] = '0; tb_size[d] = '0; tb_strobe[d] = '0; tb_wdata[d] = '0;
      last_ok[d] = 0;
      for (int w = 0; w < 1024; w++) begin
        m_known[d][w] = 1'b0;
        m_mem[d][w]   = 64'h0;
      end
    end
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_dok",   64'(w_dok[d]), 64'd0);
      chk("rst_aok",   64'(w_aok[d]), 64'd0);
      chk("rst_rdata", w_rdata[d],    64'h0);
    end
    reset = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 16; w++)
        txn(d, 64'(w * 8), 8'hFF, {$urandom, $urandom}, 1'b0, 1'b0);

    // Full then partial store to 0x10 with reloads.
    txn(0, 64'h10, 8'hFF, 64'h1122334455667788, 1'b0, 1'b0);
    txn(0, 64'h10, 8'h00, 64'h0, 1'b0, 1'b0);
    txn(0, 64'h10, 8'h0F, 64'hAAAAAAAABBBBBBBB, 1'b0, 1'b0);
    txn(0, 64'h10, 8'h00, 64'h0, 1'b0, 1'b0);
    chk("partial_word", m_mem[0][2], 64'h11223344BBBBBBBB);

    // Back-to-back store/load at LATENCY 1.
    txn(1, 64'h20, 8'hFF, {$urandom, $urandom}, 1'b0, 1'b0);
    txn(1, 64'h20, 8'h00, 64'h0, 1'b0, 1'b1);
    txn(1, 64'h20, 8'hFF, {$urandom, $urandom}, 1'b0, 1'b1);
    txn(1, 64'h20, 8'h00, 64'h0, 1'b0, 1'b1);

    // Out of range: load returns zero, store leaves word 0 (its alias) intact.
    txn(0, 64'h8000_0000, 8'h00, 64'h0, 1'b0, 1'b0);
    txn(0, 64'h8000_0000, 8'hFF, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b0);
    txn(0, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0);

    // Abort in WAIT, then reset in WAIT.
    abort_txn(0, 64'h10, 8'hFF, 64'h5555555555555555, 1);
    txn(0, 64'h10, 8'h00, 64'h0, 1'b0, 1'b0);
    tb_valid[0] = 1'b1; tb_addr[0] = 64'h10; tb_strobe[0] = 8'hFF; tb_wdata[0] = 64'h6666666666666666;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_dok",   64'(w_dok[0]), 64'd0);
    chk("rst_mid_aok",   64'(w_aok[0]), 64'd0);
    chk("rst_mid_rdata", w_rdata[0],    64'h0);
    tb_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    txn(0, 64'h10, 8'h00, 64'h0, 1'b0, 1'b0);

    // LATENCY 15 sweep.
    for (int k = 0; k < 4; k++)
      txn(2, 64'(k * 8), (k % 2 == 0) ? 8'hFF : 8'h00, {$urandom, $urandom}, 1'b0, k > 0);
    abort_txn(2, 64'h8, 8'hFF, 64'h7777777777777777, 14);
    txn(2, 64'h8, 8'h00, 64'h0, 1'b0, 1'b0);

    // Random traffic on every responder.
    for (int d = 0; d < 3; d++) begin
      lat  = lat_of(d);
      back = 1'b0;
      for (int k = 0; k < 30; k++) begin
        a = 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) a = a | (64'($urandom_range(1, 1000)) << 32);
        case ($urandom_range(0, 3))
          0, 1:    s = 8'h00;
          2:       s = 8'hFF;
          default: s = 8'($urandom);
        endcase
        if (lat > 1 && $urandom_range(0, 9) == 0) begin
          abort_txn(d, a, s, {$urandom, $urandom}, $urandom_range(1, lat - 1));
          back = 1'b0;
        end else begin
          txn(d, a, s, {$urandom, $urandom}, $urandom_range(0, 9) == 0, back);
          back = 1'b1;
        end
        if ($urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
          back = 1'b0;
        end
      end
      for (int w = 0; w < 16; w++)
        txn(d, 64'(w * 8), 8'h00, 64'h0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
